robo_atuador: RTL and testbench

//  Downstream actuator stage of the robot FSM: consumes its level commands avancar/girar/recolher_entulho
//  and drives both wheel motors (PWM + direction) and the debris claw. Soft-start/stop ramps on motors;

---
 rtl/robo_pkg.sv | 47 ++++
 rtl/robo_pwm.sv | 29 ++
 rtl/robo_atuador.sv | 169 ++++++++++++++++
 tb/tb_robo_atuador.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared encodings for the robot actuator stage: FSM states, decoded commands, duty limits.
package robo_pkg;

    typedef enum logic [3:0] {
        ST_PARADO   = 4'd0,
        ST_RAMPA    = 4'd1,
        ST_CRUZEIRO = 4'd2,
        ST_FREIO    = 4'd3,
        ST_PAUSA    = 4'd4,
        ST_DESCE    = 4'd5,
        ST_FECHA    = 4'd6,
        ST_SOBE     = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE     = 2'd0,
        CMD_AVANCAR  = 2'd1,
        CMD_GIRAR    = 2'd2,
        CMD_RECOLHER = 2'd3
    } cmd_t;

    localparam int PWM_BITS_DEF = 4;

    function automatic int duty_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic cmd_conflict(input logic a, input logic g, input logic r);
        return (a & g) | (a & r) | (g & r);
    endfunction

    // Conflicting requests collapse to NONE so the motors brake rather than guess.
    function automatic cmd_t decode_cmd(input logic a, input logic g, input logic r);
        if (cmd_conflict(a, g, r)) return CMD_NONE;
        if (a) return CMD_AVANCAR;
        if (g) return CMD_GIRAR;
        if (r) return CMD_RECOLHER;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/robo_pwm.sv
// Free-running PWM counter and comparator; output is high while counter < duty.
// Duty 0 gives a constant low, all-ones duty gives high on all but one slot per period.
module robo_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm = (pwm_cnt_q < duty);

endmodule

// File: rtl/robo_atuador.sv
// Actuator stage: soft-ramped wheel motors with dead-time direction changes and a 3-phase claw.
// Commands are registered once, so the FSM reacts two posedges after a command is applied.
module robo_atuador
    import robo_pkg::*;
#(
    parameter int PWM_BITS         = PWM_BITS_DEF,
    parameter int RAMP_STEP_CYCLES = 4,
    parameter int DEADTIME_CYCLES  = 2,
    parameter int ARM_PHASE_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic avancar,
    input  logic girar,
    input  logic recolher_entulho,
    output logic pwm_esq,
    output logic pwm_dir,
    output logic dir_esq,
    output logic dir_dir,
    output logic garra_desce,
    output logic garra_fecha,
    output logic ocupado,
    output logic erro_cmd
);

    localparam int CNT_MAX = max3(RAMP_STEP_CYCLES, DEADTIME_CYCLES, ARM_PHASE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    RAMP_LAST = CNT_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DEAD_LAST = CNT_W'(DEADTIME_CYCLES - 1);
    localparam logic [CNT_W-1:0]    ARM_LAST  = CNT_W'(ARM_PHASE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(duty_max(PWM_BITS));

    state_t              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    cmd_t                motion;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                erro_q, erro_d;
    logic                dir_esq_q, dir_esq_d;
    logic                dir_dir_q, dir_dir_d;
    logic                desce_q, desce_d;
    logic                fecha_q, fecha_d;
    logic                ocupado_q, ocupado_d;
    logic                pwm_w;

    always_comb begin
        cmd_d     = decode_cmd(avancar, girar, recolher_entulho);
        erro_d    = cmd_conflict(avancar, girar, recolher_entulho);
        state_d   = state_q;
        duty_d    = duty_q;
        dir_esq_d = dir_esq_q;
        dir_dir_d = dir_dir_q;
        cnt_d     = cnt_q + CNT_W'(1);
        // The direction pins uniquely identify which motion is in progress.
        motion    = dir_esq_q ? CMD_AVANCAR : CMD_GIRAR;

        case (state_q)
            ST_PARADO, ST_PAUSA: begin
                duty_d = '0;
                if (state_q == ST_PARADO || cnt_q == DEAD_LAST) begin
                    case (cmd_q)
                        CMD_AVANCAR: begin
                            state_d   = ST_RAMPA;
                            dir_esq_d = 1'b1;
                            dir_dir_d = 1'b1;
                        end
                        CMD_GIRAR: begin
                            state_d   = ST_RAMPA;
                            dir_esq_d = 1'b0;
                            dir_dir_d = 1'b1;
                        end
                        CMD_RECOLHER: state_d = ST_DESCE;
                        default:      state_d = ST_PARADO;
                    endcase
                end
            end
            ST_RAMPA: begin
                if (cnt_q == RAMP_LAST) cnt_d = '0;
                if (cmd_q != motion) begin
                    state_d = ST_FREIO;
                end else if (cnt_q == RAMP_LAST) begin
                    if (duty_q != DUTY_MAX) duty_d = duty_q + PWM_BITS'(1);
                    if (duty_d == DUTY_MAX) state_d = ST_CRUZEIRO;
                end
            end
            ST_CRUZEIRO: begin
                duty_d = DUTY_MAX;
                if (cmd_q != motion) state_d = ST_FREIO;
            end
            ST_FREIO: begin
                if (cnt_q == RAMP_LAST) cnt_d = '0;
                if (duty_q == '0) begin
                    state_d = ST_PAUSA;
                end else if (cnt_q == RAMP_LAST) begin
                    duty_d = duty_q - PWM_BITS'(1);
                    if (duty_d == '0) state_d = ST_PAUSA;
                end
            end
            ST_DESCE: begin
                duty_d = '0;
                if (cnt_q == ARM_LAST) state_d = ST_FECHA;
            end
            ST_FECHA: begin
                duty_d = '0;
                if (cnt_q == ARM_LAST) state_d = ST_SOBE;
            end
            ST_SOBE: begin
                duty_d = '0;
                if (cnt_q == ARM_LAST) state_d = ST_PARADO;
            end
            default: begin
                state_d = ST_PARADO;
                duty_d  = '0;
            end
        endcase

        if (state_d != state_q || state_q == ST_PARADO || state_q == ST_CRUZEIRO) cnt_d = '0;

        desce_d   = (state_d == ST_DESCE) || (state_d == ST_FECHA);
        fecha_d   = (state_d == ST_FECHA) || (state_d == ST_SOBE);
        ocupado_d = (state_d != ST_PARADO) || (duty_d != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PARADO;
            cmd_q     <= CMD_NONE;
            duty_q    <= '0;
            cnt_q     <= '0;
            erro_q    <= 1'b0;
            dir_esq_q <= 1'b0;
            dir_dir_q <= 1'b0;
            desce_q   <= 1'b0;
            fecha_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            erro_q    <= erro_d;
            dir_esq_q <= dir_esq_d;
            dir_dir_q <= dir_dir_d;
            desce_q   <= desce_d;
            fecha_q   <= fecha_d;
            ocupado_q <= ocupado_d;
        end
    end

    robo_pwm #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clock(clock),
        .reset(reset),
        .duty (duty_q),
        .pwm  (pwm_w)
    );

    assign pwm_esq     = pwm_w;
    assign pwm_dir     = pwm_w;
    assign dir_esq     = dir_esq_q;
    assign dir_dir     = dir_dir_q;
    assign garra_desce = desce_q;
    assign garra_fecha = fecha_q;
    assign ocupado     = ocupado_q;
    assign erro_cmd    = erro_q;

endmodule

// File: tb/tb_robo_atuador.sv
// Bench for robo_atuador: per-scenario expected output timelines queued as stimulus is applied.
module tb_robo_atuador;

    logic clock = 1'b0;
    logic reset;
    logic avancar, girar, recolher_entulho;
    logic pwm_esq, pwm_dir, dir_esq, dir_dir, garra_desce, garra_fecha, ocupado, erro_cmd;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] outs;
    logic [3:0] pcnt;
    logic [1:0] cur_dir;

    robo_atuador dut (
        .clock           (clock),
        .reset           (reset),
        .avancar         (avancar),
        .girar           (girar),
        .recolher_entulho(recolher_entulho),
        .pwm_esq         (pwm_esq),
        .pwm_dir         (pwm_dir),
        .dir_esq         (dir_esq),
        .dir_dir         (dir_dir),
        .garra_desce     (garra_desce),
        .garra_fecha     (garra_fecha),
        .ocupado         (ocupado),
        .erro_cmd        (erro_cmd)
    );

    always #5 clock = ~clock;

    assign outs = {pwm_esq, pwm_dir, dir_esq, dir_dir, garra_desce, garra_fecha, ocupado, erro_cmd};

    // Expected PWM phase: slot index counts posedges since reset release.
    always @(posedge clock or negedge reset) begin
        if (!reset) pcnt <= 4'd0;
        else        pcnt <= pcnt + 4'd1;
    end

    // Expected outputs one posedge ahead of the current negedge.
    function automatic logic [7:0] exp_vec(input int duty, input logic [1:0] dir,
                                           input logic ds, input logic fc,
                                           input logic oc, input logic er);
        logic [3:0] nxt;
        logic       pw;
        nxt = pcnt + 4'd1;
        pw  = (int'(nxt) < duty);
        return {pw, pw, dir, ds, fc, oc, er};
    endfunction

    task automatic set_in(input logic a, input logic g, input logic r);
        avancar          = a;
        girar            = g;
        recolher_entulho = r;
    endtask

    task automatic test_reset;
        logic [7:0] want;
        set_in(0, 0, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", outs, 8'h00);
        end
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(exp_vec(0, 2'b00, 0, 0, 0, 0));
            @(negedge clock);
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b want=%b", k, outs, want);
            end
        end
        cur_dir = 2'b00;
    endtask

    task automatic test_ramp;
        logic [7:0] want;
        int duty;
        int highs;
        highs = 0;
        for (int k = 1; k <= 80; k++) begin
            set_in(1, 0, 0);
            if (k < 2) begin
                exp_q.push_back(exp_vec(0, cur_dir, 0, 0, 0, 0));
            end else begin
                duty = (k - 2) / 4;
                if (duty > 15) duty = 15;
                exp_q.push_back(exp_vec(duty, 2'b11, 0, 0, 1, 0));
            end
            @(negedge clock);
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL ramp k=%0d got=%b want=%b", k, outs, want);
            end
            if (k >= 63 && k <= 78 && pwm_esq === 1'b1) highs++;
        end
        checks++;
        if (highs != 15) begin
            errors++;
            $display("FAIL cruise_pwm_high got=%0d want=15", highs);
        end
        cur_dir = 2'b11;
    endtask

    task automatic test_turn;
        logic [7:0] want;
        int duty;
        int n;
        for (int k = 1; k <= 90; k++) begin
            set_in(0, 1, 0);
            if (k < 2)       exp_q.push_back(exp_vec(15, 2'b11, 0, 0, 1, 0));
            else if (k < 62) exp_q.push_back(exp_vec(15 - (k - 2) / 4, 2'b11, 0, 0, 1, 0));
            else if (k < 64) exp_q.push_back(exp_vec(0, 2'b11, 0, 0, 1, 0));
            else begin
                duty = (k - 64) / 4;
                exp_q.push_back(exp_vec(duty, 2'b01, 0, 0, 1, 0));
            end
            @(negedge clock);
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL turn k=%0d got=%b want=%b", k, outs, want);
            end
        end
        set_in(0, 0, 0);
        n = 0;
        while (ocupado !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL turn_drain got=%b want=0", ocupado);
        end
        cur_dir = 2'b01;
    endtask

    task automatic test_claw;
        logic [7:0] want;
        for (int k = 1; k <= 30; k++) begin
            set_in(0, 0, k == 1);
            if (k < 2)       exp_q.push_back(exp_vec(0, cur_dir, 0, 0, 0, 0));
            else if (k < 10) exp_q.push_back(exp_vec(0, cur_dir, 1, 0, 1, 0));
            else if (k < 18) exp_q.push_back(exp_vec(0, cur_dir, 1, 1, 1, 0));
            else if (k < 26) exp_q.push_back(exp_vec(0, cur_dir, 0, 1, 1, 0));
            else             exp_q.push_back(exp_vec(0, cur_dir, 0, 0, 0, 0));
            @(negedge clock);
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL claw k=%0d got=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_error;
        logic [7:0] want;
        logic er;
        for (int k = 1; k <= 44; k++) begin
            if (k <= 20)      set_in(1, 0, 0);
            else if (k <= 23) set_in(1, 1, 0);
            else              set_in(0, 0, 0);
            er = (k >= 21 && k <= 23);
            if (k < 2)       exp_q.push_back(exp_vec(0, cur_dir, 0, 0, 0, er));
            else if (k < 22) exp_q.push_back(exp_vec((k - 2) / 4, 2'b11, 0, 0, 1, er));
            else if (k < 38) exp_q.push_back(exp_vec(4 - (k - 22) / 4, 2'b11, 0, 0, 1, er));
            else if (k < 40) exp_q.push_back(exp_vec(0, 2'b11, 0, 0, 1, er));
            else             exp_q.push_back(exp_vec(0, 2'b11, 0, 0, 0, er));
            @(negedge clock);
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL conflict k=%0d got=%b want=%b", k, outs, want);
            end
        end
        cur_dir = 2'b11;
    endtask

    task automatic test_recolher_cruise;
        logic [7:0] want;
        int duty;
        for (int k = 1; k <= 160; k++) begin
            if (k <= 65)                set_in(1, 0, 0);
            else if (k <= 130)          set_in(0, 0, 1);
            else if (k >= 136 && k <= 138) set_in(1, 0, 0);
            else                        set_in(0, 0, 0);
            if (k < 2) begin
                exp_q.push_back(exp_vec(0, cur_dir, 0, 0, 0, 0));
            end else if (k < 67) begin
                duty = (k - 2) / 4;
                if (duty > 15) duty = 15;
                exp_q.push_back(exp_vec(duty, 2'b11, 0, 0, 1, 0));
            end
            else if (k < 128) exp_q.push_back(exp_vec(15 - (k - 67) / 4, 2'b11, 0, 0, 1, 0));
            else if (k < 129) exp_q.push_back(exp_vec(0, 2'b11, 0, 0, 1, 0));
            else if (k < 137) exp_q.push_back(exp_vec(0, 2'b11, 1, 0, 1, 0));
            else if (k < 145) exp_q.push_back(exp_vec(0, 2'b11, 1, 1, 1, 0));
            else if (k < 153) exp_q.push_back(exp_vec(0, 2'b11, 0, 1, 1, 0));
            else              exp_q.push_back(exp_vec(0, 2'b11, 0, 0, 0, 0));
            @(negedge clock);
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL recolher_cruise k=%0d got=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_reset_mid_cruise;
        logic [7:0] want;
        set_in(1, 0, 0);
        repeat (70) @(negedge clock);
        checks++;
        if ({ocupado, dir_esq, dir_dir} !== 3'b111) begin
            errors++;
            $display("FAIL pre_reset_cruise got=%b want=111", {ocupado, dir_esq, dir_dir});
        end
        #2;
        reset = 1'b0;
        set_in(0, 0, 0);
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got=%b want=%b", outs, 8'h00);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back(exp_vec(0, 2'b00, 0, 0, 0, 0));
            @(negedge clock);
            want = exp_q.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL post_reset k=%0d got=%b want=%b", k, outs, want);
            end
        end
        cur_dir = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0);
        cur_dir = 2'b00;
        test_reset;
        test_ramp;
        test_turn;
        test_claw;
        test_error;
        test_recolher_cruise;
        test_reset_mid_cruise;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
